alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared single-cycle-registered ALU (ADD/SUB/AND/OR/SLL/RL/SRL/SRA, 4-bit shift immediate). Accepts operations from two requesters via valid/ready, issues at most one per cycle to the ALU, and routes each registered result back to its owner. Per-requester {Z,V,N} flags are computed at writeback, and a one-entry hold buffer per requester absorbs response backpressure.

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for a shared registered ALU, with per-requester response
// hold buffers and {Z,V,N} flags. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module alu_arbiter #(
    parameter int unsigned DSIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DSIZE-1:0] req0_a,
    input  logic [DSIZE-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic [3:0]       req0_imm,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DSIZE-1:0] req1_a,
    input  logic [DSIZE-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic [3:0]       req1_imm,
    output logic [DSIZE-1:0] alu_a,
    output logic [DSIZE-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_imm,
    input  logic [DSIZE-1:0] alu_out,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [DSIZE-1:0] rsp0_data,
    output logic [2:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [DSIZE-1:0] rsp1_data,
    output logic [2:0]       rsp1_flags
);

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic last_grant_q;
`endif
    logic                       inflight_valid_q;
    logic                       inflight_id_q;
    logic [2:0]                 inflight_op_q;
    logic                       inflight_a_msb_q;
    logic                       inflight_b_msb_q;
    logic [1:0]                 hold_valid_q;
    logic [1:0][DSIZE-1:0]      hold_data_q;
    logic [1:0][2:0]            flags_q;

    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] inflight_own;
    logic [1:0] elig;
    logic       gnt_valid;
    logic       gnt_id;
    logic       wb_z;
    logic       wb_v;
    logic       wb_n;
    logic       res_msb;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            inflight_own[n] = inflight_valid_q & (inflight_id_q == 1'(n));
            // An owner with a result in flight may issue again only if it consumes it now.
            elig[n] = req_valid[n] & ~hold_valid_q[n] & (~inflight_own[n] | rsp_ready[n]);
        end
    end

    always_comb begin
        gnt_valid = rst_n & (|elig);
        gnt_id    = 1'b0;
        if (elig == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gnt_id = 1'b0;
`else
            gnt_id = ~last_grant_q;
`endif
        end else begin
            gnt_id = elig[1];
        end
    end

    assign req0_ready = gnt_valid & ~gnt_id;
    assign req1_ready = gnt_valid & gnt_id;

    assign alu_a   = !gnt_valid ? '0 : (gnt_id ? req1_a   : req0_a);
    assign alu_b   = !gnt_valid ? '0 : (gnt_id ? req1_b   : req0_b);
    assign alu_op  = !gnt_valid ? '0 : (gnt_id ? req1_op  : req0_op);
    assign alu_imm = !gnt_valid ? '0 : (gnt_id ? req1_imm : req0_imm);

    assign rsp0_valid = hold_valid_q[0] | inflight_own[0];
    assign rsp1_valid = hold_valid_q[1] | inflight_own[1];
    assign rsp0_data  = hold_valid_q[0] ? hold_data_q[0] : (inflight_own[0] ? alu_out : '0);
    assign rsp1_data  = hold_valid_q[1] ? hold_data_q[1] : (inflight_own[1] ? alu_out : '0);
    assign rsp0_flags = flags_q[0];
    assign rsp1_flags = flags_q[1];

    assign res_msb = alu_out[DSIZE-1];

    always_comb begin
        wb_z = (alu_out == '0);
        wb_v = 1'b0;
        wb_n = res_msb;
        unique case (inflight_op_q[1:0])
            2'b00: begin
                wb_v = (inflight_a_msb_q == inflight_b_msb_q) & (res_msb != inflight_a_msb_q);
                wb_n = res_msb ^ wb_v;
            end
            2'b01: begin
                wb_v = (inflight_a_msb_q != inflight_b_msb_q) & (res_msb != inflight_a_msb_q);
                wb_n = res_msb ^ wb_v;
            end
            default: begin
                wb_v = 1'b0;
                wb_n = res_msb;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
            inflight_valid_q <= 1'b0;
            inflight_id_q    <= 1'b0;
            inflight_op_q    <= '0;
            inflight_a_msb_q <= 1'b0;
            inflight_b_msb_q <= 1'b0;
            hold_valid_q     <= '0;
            hold_data_q      <= '0;
            flags_q          <= '0;
        end else begin
`ifndef ALU_ARB_FIXED_PRIO_EN
            if (gnt_valid) last_grant_q <= gnt_id;
`endif
            inflight_valid_q <= gnt_valid;
            if (gnt_valid) begin
                inflight_id_q    <= gnt_id;
                inflight_op_q    <= alu_op;
                inflight_a_msb_q <= alu_a[DSIZE-1];
                inflight_b_msb_q <= alu_b[DSIZE-1];
            end
            for (int n = 0; n < 2; n++) begin
                if (hold_valid_q[n] && rsp_ready[n]) hold_valid_q[n] <= 1'b0;
                if (inflight_own[n] && !rsp_ready[n]) begin
                    hold_valid_q[n] <= 1'b1;
                    hold_data_q[n]  <= alu_out;
                end
                // Flags track writeback, not consumption; shifts leave them alone.
                if (inflight_own[n] && !inflight_op_q[2]) flags_q[n] <= {wb_z, wb_v, wb_n};
            end
        end
    end

endmodule
